rto_fifo_arbiter: RTL and testbench
===================================

Name: rto_fifo_arbiter

Overview:
- Shares the single RTO_Core FIFO write port between NUM_REQ timed-event producers: the AXI2FIFO write path, an on-chip waveform sequencer and future list players.
- Round-robin burst arbitration, so a producer's group of same-timestamp entries lands contiguously in the FIFO.
- Sits between the producers and RTO_Core's write/fifo_din/full/flush, in the s_axi_aclk domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 128, FIFO entry width.
- TS_LSB, 64, LSB of the 64-bit timestamp field inside an entry.
- MAX_BURST, 8, maximum consecutive writes per grant (1..255).

Ports:
- s_axi_aclk  in  1  single clock.
- s_axi_aresetn  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester entry valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed entries; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept.
- flush  in  1  flush request, shared with RTO_Core.
- fifo_full  in  1  RTO_Core full.
- fifo_write  out  1  RTO_Core write strobe.
- fifo_din  out  DATA_WIDTH  RTO_Core write data.
- grant_id  out  $clog2(NUM_REQ)  current or last granted requester.
- busy  out  1  state != IDLE.
- order_error  out  1  sticky timestamp-order violation.
- order_error_id  out  $clog2(NUM_REQ)  requester of the first violation.

Behaviour:
- Reset values: state IDLE, rr_ptr 0, grant_id 0, beat_cnt 0, last_ts 0, order_error 0, order_error_id 0.
- Reset outputs: req_ready 0, fifo_write 0, fifo_din 0, busy 0.
- IDLE:
  - flush high -> FLUSH.
  - Otherwise, if any req_valid, pick the first valid index searching upward from rr_ptr with wrap.
  - Register grant_id = winner, beat_cnt = 0, -> GRANT.
  - No writes in IDLE; arbitration costs one cycle per burst.
- GRANT, with g = grant_id:
  - Handshake = req_valid[g] & ~fifo_full & ~flush.
  - req_ready[g] = ~fifo_full & ~flush; all other ready bits are 0.
  - fifo_write = handshake & entry accepted. fifo_din = req_data[g], combinational and zero-latency to RTO_Core.
  - On handshake: beat_cnt++.
  - If beat_cnt == MAX_BURST-1 on a handshake: exit.
  - If req_valid[g] is low: exit.
  - Exit means -> IDLE, rr_ptr <= (g+1) mod NUM_REQ.
  - fifo_full high: hold the grant, no write, beat_cnt unchanged.
- FLUSH:
  - Entered from any state on flush high; a GRANT cycle with flush high performs no write.
  - All ready 0, fifo_write 0.
  - last_ts <= 0, order_error <= 0, rr_ptr <= 0.
  - Stays while flush is high; -> IDLE on the first cycle flush is low.
- Simultaneous events:
  - flush has priority over full and valid.
  - Requester valid dropping on the same cycle as the MAX_BURST beat is a single exit.
- Wrap-around: rr_ptr wraps from NUM_REQ-1 to 0. Non-power-of-two NUM_REQ must never select an index >= NUM_REQ.
- Reset mid-burst: immediate return to reset values. A partially written group is the producer's concern; software flushes after reset.

Optional Feature:
- Macro RTO_ORDER_CHECK_EN.
- Defined, with ts = entry[TS_LSB+63:TS_LSB]:
  - On each GRANT handshake, if ts < last_ts (unsigned), the entry is consumed (ready high) but fifo_write stays 0.
  - order_error <= 1; order_error_id latched only on the first violation since reset or flush.
  - Otherwise the entry is written and last_ts <= ts. Equal timestamps are legal.
- Undefined: every handshaken entry is written; last_ts is not implemented; order_error and order_error_id are tied 0.

Decomposition:
- Package rto_arb_pkg:
  - typedef arb_state_t {IDLE, GRANT, FLUSH}.
  - Constant TS_WIDTH = 64.
  - Function rr_pick(valid, ptr, n) returning the winner index.
- One sub-module, rr_arbiter_core: combinational round-robin search plus the rr_ptr register, reusable by other shared-port controllers.

Test Plan:
- Reset, then req_valid=4'b0101 held with 3 entries each -> grants 0,2,0,2 rotating. Each burst: 1 IDLE cycle, then 1 write per cycle. fifo_din matches the data sequence.
- Requester 1 holds valid for 20 entries, MAX_BURST=8, other requesters idle -> bursts of 8,8,4 with one IDLE cycle between; busy low after the last write.
- fifo_full forced high for 5 cycles mid-burst -> no fifo_write, req_ready 0, grant held. The burst resumes with beat_cnt unchanged and no data lost or duplicated.
- flush pulsed 3 cycles during GRANT -> no write that cycle, FLUSH for 3 cycles, then IDLE. rr_ptr=0; order_error cleared.
- (RTO_ORDER_CHECK_EN) Requester 3 writes ts 100, 100, 50, 200 -> writes 100, 100, 200. order_error=1, order_error_id=3; ready high on all four beats.
- Asynchronous reset asserted mid-burst between clock edges -> outputs go to reset values immediately. After release, normal arbitration from requester 0.

Source files
------------

// File: rtl/rto_arb_pkg.sv
// Shared types and helpers for the RTO FIFO write-port arbiter.
// Holds the arbiter state encoding, the timestamp field width and the
// round-robin search function used by rr_arbiter_core.
package rto_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FLUSH = 2'd2
  } arb_state_t;

  localparam int TS_WIDTH = 64;
  localparam int MAX_REQ  = 8;

  // First set bit of valid, searching upward from ptr and wrapping at n.
  // Only indices below n are ever visited, so a non-power-of-two n can
  // never yield an out-of-range winner. Returns ptr when nothing is valid.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input int unsigned        ptr,
                                          input int unsigned        n);
    int unsigned idx;
    int unsigned win;
    logic        found;
    found = 1'b0;
    win   = ptr;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (!found && (i < n) && valid[idx[2:0]]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Round-robin search plus the rotating priority pointer. Generic enough to
// be dropped into any shared-port controller: the owner tells it when a
// grant finishes (adv_i with the finished index) or when to restart from 0.
module rr_arbiter_core
  import rto_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         valid_i,
  input  logic                       adv_i,
  input  logic [$clog2(NUM_REQ)-1:0] adv_idx_i,
  input  logic                       clr_i,
  output logic [$clog2(NUM_REQ)-1:0] winner_o,
  output logic                       any_valid_o,
  output logic [$clog2(NUM_REQ)-1:0] ptr_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   ptr_d;
  logic [MAX_REQ-1:0] valid_ext;

  // Winner search over the zero-extended request vector.
  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = valid_i;
    winner_o                 = IDX_W'(rr_pick(valid_ext, int'(ptr_q), NUM_REQ));
    any_valid_o              = |valid_i;
  end

  // Next pointer: clear wins, otherwise step past the finished grant.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (adv_i) begin
      ptr_d = (adv_idx_i == IDX_W'(NUM_REQ - 1)) ? '0 : adv_idx_i + IDX_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rto_fifo_arbiter.sv
// Shares the RTO_Core FIFO write port between NUM_REQ timed-event producers
// with round-robin burst grants, so a producer's same-timestamp group lands
// contiguously. fifo_din/fifo_write are combinational from the granted
// requester so a write reaches RTO_Core in the accepting cycle.
// Optional build macro RTO_ORDER_CHECK_EN: drops entries whose timestamp
// goes backwards and flags them in a sticky order_error.
//
// state | meaning
// IDLE  | no grant; one arbitration cycle picks the next requester
// GRANT | grant_id owns the write port for up to MAX_BURST beats
// FLUSH | flush held high; everything quiet, pointer and order state cleared
module rto_fifo_arbiter
  import rto_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 128,
  parameter int TS_LSB     = 64,
  parameter int MAX_BURST  = 8
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          flush,
  input  logic                          fifo_full,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          order_error,
  output logic [$clog2(NUM_REQ)-1:0]    order_error_id
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("rto_fifo_arbiter: NUM_REQ must be 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("rto_fifo_arbiter: MAX_BURST must be 1..255");
  end
  if (TS_LSB + TS_WIDTH > DATA_WIDTH) begin : g_bad_ts_lsb
    $error("rto_fifo_arbiter: timestamp field exceeds entry width");
  end

  arb_state_t       state_q;
  logic [IDX_W-1:0] grant_q;
  logic [7:0]       beat_q;

  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  in_grant;
  logic                  handshake;
  logic                  last_beat;
  logic                  ts_ok;
  logic                  rr_adv;
  logic                  rr_clr;
  logic [IDX_W-1:0]      rr_winner;
  logic                  rr_any;
  logic [IDX_W-1:0]      rr_ptr;

  // Mux out the granted requester's valid and entry.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = req_valid[i];
      end
    end
  end

  // Handshake, burst exit and port outputs; flush masks everything.
  always_comb begin
    in_grant   = (state_q == GRANT);
    handshake  = in_grant & sel_valid & ~fifo_full & ~flush;
    last_beat  = (beat_q == 8'(MAX_BURST - 1));
    fifo_write = handshake & ts_ok;
    fifo_din   = in_grant ? sel_data : '0;
    req_ready  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (in_grant && grant_q == IDX_W'(i)) req_ready[i] = ~fifo_full & ~flush;
    end
    rr_adv     = in_grant & ~flush & (~sel_valid | (handshake & last_beat));
    rr_clr     = (state_q == FLUSH);
  end

  rr_arbiter_core #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk         (s_axi_aclk),
    .rst_n       (s_axi_aresetn),
    .valid_i     (req_valid),
    .adv_i       (rr_adv),
    .adv_idx_i   (grant_q),
    .clr_i       (rr_clr),
    .winner_o    (rr_winner),
    .any_valid_o (rr_any),
    .ptr_o       (rr_ptr)
  );

  // Arbiter FSM: grant selection, burst counting and flush handling.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush) begin
            state_q <= FLUSH;
          end else if (rr_any) begin
            grant_q <= rr_winner;
            beat_q  <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (flush) begin
            state_q <= FLUSH;
          end else if (!sel_valid) begin
            state_q <= IDLE;
          end else if (handshake) begin
            beat_q <= beat_q + 8'd1;
            if (last_beat) state_q <= IDLE;
          end
        end
        FLUSH: begin
          if (!flush) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);

`ifdef RTO_ORDER_CHECK_EN
  logic [TS_WIDTH-1:0] last_ts_q;
  logic                order_err_q;
  logic [IDX_W-1:0]    order_err_id_q;
  logic [TS_WIDTH-1:0] entry_ts;

  assign entry_ts = sel_data[TS_LSB +: TS_WIDTH];
  assign ts_ok    = (entry_ts >= last_ts_q);

  // Timestamp monotonicity tracking; a backwards entry is consumed unwritten.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      last_ts_q      <= '0;
      order_err_q    <= 1'b0;
      order_err_id_q <= '0;
    end else if (state_q == FLUSH) begin
      last_ts_q   <= '0;
      order_err_q <= 1'b0;
    end else if (handshake) begin
      if (ts_ok) begin
        last_ts_q <= entry_ts;
      end else begin
        order_err_q <= 1'b1;
        if (!order_err_q) order_err_id_q <= grant_q;
      end
    end
  end

  assign order_error    = order_err_q;
  assign order_error_id = order_err_id_q;
`else
  assign ts_ok          = 1'b1;
  assign order_error    = 1'b0;
  assign order_error_id = '0;
`endif

endmodule

// File: tb/tb_rto_fifo_arbiter.sv
// Scoreboard bench for rto_fifo_arbiter: expected writes are queued as
// stimulus is issued; a negedge monitor pops and compares on every write.
module tb_rto_fifo_arbiter;

  localparam int NR = 4;
  localparam int DW = 128;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NR-1:0]      req_valid = '0;
  logic [NR*DW-1:0]   req_data = '0;
  logic [NR-1:0]      req_ready;
  logic               flush = 1'b0;
  logic               fifo_full = 1'b0;
  logic               fifo_write;
  logic [DW-1:0]      fifo_din;
  logic [1:0]         grant_id;
  logic               busy;
  logic               order_error;
  logic [1:0]         order_error_id;

  rto_fifo_arbiter dut (
    .s_axi_aclk     (clk),
    .s_axi_aresetn  (rst_n),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .flush          (flush),
    .fifo_full      (fifo_full),
    .fifo_write     (fifo_write),
    .fifo_din       (fifo_din),
    .grant_id       (grant_id),
    .busy           (busy),
    .order_error    (order_error),
    .order_error_id (order_error_id)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int            id;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          expq[$];
  logic [DW-1:0] pq[NR][$];
  int            hs_cnt[NR] = '{default: 0};
  int            wr_cnt = 0;
  int            runs[$];
  int            gaps[$];
  int            run_len = 0;
  int            gap_len = 0;
  bit            mon_seen = 1'b0;
  logic [NR-1:0] hs_v;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int id, input int seq, input longint unsigned ts);
    return {ts, 32'(id), 32'(seq)};
  endfunction

  task automatic load(input int id, input int seq, input longint unsigned ts);
    pq[id].push_back(mk(id, seq, ts));
  endtask

  task automatic expect_wr(input int id, input int seq, input longint unsigned ts);
    exp_t e;
    e.id = id;
    e.d  = mk(id, seq, ts);
    expq.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_writes(input string nm, input int target, input int budget);
    int k;
    k = 0;
    while (wr_cnt < target && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(nm, 128'(wr_cnt >= target), 128'(1));
  endtask

  task automatic mon_clear();
    runs.delete();
    gaps.delete();
    mon_seen = 1'b0;
  endtask

  // Producer model: pop an entry after each accepted handshake.
  initial begin
    forever begin
      @(negedge clk);
      hs_v = req_valid & req_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < NR; i++) begin
        if (hs_v[i] && pq[i].size() > 0) begin
          void'(pq[i].pop_front());
          hs_cnt[i]++;
        end
      end
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = (pq[i].size() > 0);
        req_data[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0] : '0;
      end
    end
  end

  // Write monitor: scoreboard compare plus burst-run / gap bookkeeping.
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
      gap_len = 0;
    end else if (fifo_write) begin
      exp_t e;
      wr_cnt++;
      if (run_len == 0 && mon_seen) gaps.push_back(gap_len);
      run_len++;
      gap_len  = 0;
      mon_seen = 1'b1;
      if (expq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got %h expected no write", fifo_din);
      end else begin
        e = expq.pop_front();
        chk("write_data", fifo_din, e.d);
        chk("write_id", 128'(grant_id), 128'(e.id));
      end
    end else begin
      if (run_len > 0) begin
        runs.push_back(run_len);
        run_len = 0;
      end
      gap_len++;
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ready", 128'(req_ready), 128'(0));
    chk("rst_write", 128'(fifo_write), 128'(0));
    chk("rst_din", fifo_din, '0);
    chk("rst_grant", 128'(grant_id), 128'(0));
    chk("rst_oerr", 128'(order_error), 128'(0));
    chk("rst_oerr_id", 128'(order_error_id), 128'(0));
    rst_n = 1'b1;
    cyc(2);

    // Two requesters, 3 entries each, two rounds: 0,2,0,2
    mon_clear();
    base = wr_cnt;
    for (int s = 0; s < 3; s++) begin load(0, s, 0); load(2, s, 0); end
    for (int s = 0; s < 3; s++) expect_wr(0, s, 0);
    for (int s = 0; s < 3; s++) expect_wr(2, s, 0);
    wait_writes("t1_round1", base + 6, 100);
    cyc(4);
    chk("t1_runs_n", 128'(runs.size()), 128'(2));
    if (runs.size() == 2) begin
      chk("t1_run0", 128'(runs[0]), 128'(3));
      chk("t1_run1", 128'(runs[1]), 128'(3));
    end
    for (int s = 3; s < 6; s++) begin load(0, s, 0); load(2, s, 0); end
    for (int s = 3; s < 6; s++) expect_wr(0, s, 0);
    for (int s = 3; s < 6; s++) expect_wr(2, s, 0);
    wait_writes("t1_round2", base + 12, 100);
    cyc(4);

    // Long stream from requester 1: bursts 8,8,4 with one IDLE cycle between
    mon_clear();
    base = wr_cnt;
    for (int s = 0; s < 20; s++) begin load(1, s, 0); expect_wr(1, s, 0); end
    wait_writes("t2_done", base + 20, 200);
    cyc(4);
    chk("t2_busy_low", 128'(busy), 128'(0));
    chk("t2_runs_n", 128'(runs.size()), 128'(3));
    if (runs.size() == 3) begin
      chk("t2_run0", 128'(runs[0]), 128'(8));
      chk("t2_run1", 128'(runs[1]), 128'(8));
      chk("t2_run2", 128'(runs[2]), 128'(4));
    end
    chk("t2_gaps_n", 128'(gaps.size()), 128'(2));
    if (gaps.size() == 2) begin
      chk("t2_gap0", 128'(gaps[0]), 128'(1));
      chk("t2_gap1", 128'(gaps[1]), 128'(1));
    end

    // fifo_full held 5 cycles mid-burst
    base = wr_cnt;
    for (int s = 0; s < 6; s++) begin load(3, s, 0); expect_wr(3, s, 0); end
    wait_writes("t3_start", base + 2, 100);
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_full_write", 128'(fifo_write), 128'(0));
      chk("t3_full_ready", 128'(req_ready), 128'(0));
      chk("t3_full_grant", 128'(grant_id), 128'(3));
      chk("t3_full_busy", 128'(busy), 128'(1));
      @(posedge clk);
      #1;
    end
    fifo_full = 1'b0;
    wait_writes("t3_done", base + 6, 100);
    cyc(4);
    chk("t3_written", 128'(wr_cnt - base), 128'(6));

`ifdef RTO_ORDER_CHECK_EN
    // Backwards timestamp is consumed but not written
    base = wr_cnt;
    h0   = hs_cnt[3];
    load(3, 0, 100); load(3, 1, 100); load(3, 2, 50); load(3, 3, 200);
    expect_wr(3, 0, 100); expect_wr(3, 1, 100); expect_wr(3, 3, 200);
    wait_writes("t5_done", base + 3, 100);
    cyc(4);
    chk("t5_consumed", 128'(hs_cnt[3] - h0), 128'(4));
    chk("t5_written", 128'(wr_cnt - base), 128'(3));
    chk("t5_oerr", 128'(order_error), 128'(1));
    chk("t5_oerr_id", 128'(order_error_id), 128'(3));
`else
    chk("t5_oerr_tied", 128'(order_error), 128'(0));
`endif

    // Flush pulse for 3 cycles during a grant; pointer must restart at 0
    base = wr_cnt;
    load(1, 10, 1000); load(1, 11, 1000);
    expect_wr(1, 10, 1000); expect_wr(1, 11, 1000);
    wait_writes("t4_pre", base + 2, 100);
    cyc(3);
    for (int s = 10; s < 16; s++) load(2, s, 1000);
    expect_wr(2, 10, 1000);
    expect_wr(1, 20, 1000); expect_wr(1, 21, 1000);
    for (int s = 11; s < 16; s++) expect_wr(2, s, 1000);
    wait_writes("t4_first", base + 3, 100);
    flush = 1'b1;
    @(negedge clk);
    chk("t4_flush_write", 128'(fifo_write), 128'(0));
    chk("t4_flush_ready", 128'(req_ready), 128'(0));
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin load(1, 20, 1000); load(1, 21, 1000); end
      if (k == 3) flush = 1'b0;
      @(negedge clk);
      chk("t4_fl_busy", 128'(busy), 128'(1));
      chk("t4_fl_write", 128'(fifo_write), 128'(0));
      chk("t4_fl_ready", 128'(req_ready), 128'(0));
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t4_idle", 128'(busy), 128'(0));
    chk("t4_oerr_clr", 128'(order_error), 128'(0));
    @(posedge clk);
    #1;
    wait_writes("t4_done", base + 10, 200);
    cyc(4);

    // Asynchronous reset mid-burst between clock edges
    base = wr_cnt;
    for (int s = 30; s < 38; s++) begin load(2, s, 2000); expect_wr(2, s, 2000); end
    wait_writes("t6_start", base + 2, 100);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_write", 128'(fifo_write), 128'(0));
    chk("t6_rst_ready", 128'(req_ready), 128'(0));
    chk("t6_rst_busy", 128'(busy), 128'(0));
    chk("t6_rst_grant", 128'(grant_id), 128'(0));
    chk("t6_rst_din", fifo_din, '0);
    chk("t6_rst_oerr", 128'(order_error), 128'(0));
    expq.delete();
    for (int i = 0; i < NR; i++) pq[i].delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = wr_cnt;
    load(0, 40, 0); load(0, 41, 0); load(3, 40, 0); load(3, 41, 0);
    expect_wr(0, 40, 0); expect_wr(0, 41, 0); expect_wr(3, 40, 0); expect_wr(3, 41, 0);
    wait_writes("t6_done", base + 4, 100);
    cyc(4);
    chk("t6_busy_end", 128'(busy), 128'(0));

    chk("final_scoreboard_empty", 128'(expq.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
